matmult_core: RTL and testbench
===============================

Name: matmult_core

Overview:
Compute engine of the matmult IP, directly downstream of the S00_AXI register slave. The slave decodes AXI4-Lite writes into element writes for operand matrices A and B, and pulses start. This block computes C = A x B for N x N matrices, one multiply-accumulate per cycle. The slave reads C back through a registered read port.

Parameters:
N, 2, matrix dimension (square); legal values 2..8
DW, 8, operand element width in bits
IW, $clog2(N*N), element index width (localparam, derived)
CW, 2*DW+$clog2(N), result element width (localparam, derived)

Ports:
ACLK  in  1  clock; all state updates on the rising edge
ARESETN  in  1  asynchronous, active-low reset
wr_en  in  1  element write strobe
wr_sel  in  1  target matrix: 0 = A, 1 = B
wr_addr  in  IW  row-major index, i*N+k
wr_data  in  DW  element value
start  in  1  one-cycle start request
busy  out  1  high while computing
done  out  1  one-cycle completion pulse
rd_addr  in  IW  row-major C index
rd_data  out  CW  C[rd_addr], registered

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; all A, B and C elements are cleared to 0.
  - busy=0, done=0, rd_data=0; i, j, k and acc are cleared to 0.
- FSM states: IDLE, MAC, DONE.
  - IDLE: start=1 at the edge -> MAC with i=j=k=0 and acc=0.
  - MAC, each cycle:
    - prod = A[i*N+k] * B[k*N+j], computed unsigned.
    - If k<N-1: acc += prod; k++.
    - If k==N-1: C[i*N+j] = acc+prod; acc=0; k=0; advance j, and wrap j into i.
    - After the last element (i=j=k=N-1) -> DONE.
  - DONE: one cycle, then IDLE.
- Outputs: busy=1 exactly while in MAC; done=1 exactly while in DONE.
- Latency: start sampled at edge t -> busy high for the N^3 cycles after t, done high in the following cycle.
  - For N=2: 8 busy cycles, done in cycle t+9.
- Arithmetic: products are 2*DW bits and the accumulator is CW bits, so no overflow is possible. Operands are zero-extended.
- Writes:
  - Accepted in IDLE and DONE.
  - Ignored while busy=1; no error indication.
  - A write and a start at the same edge: the write lands, and the computation uses the new value.
- start while busy or in DONE: ignored, not queued.
- rd_data: equals C[rd_addr] one cycle after rd_addr is presented.
  - Legal in any state. During MAC it returns current C contents: already-updated elements new, the rest from the previous run.
- Out-of-range indices (>= N*N, only possible when N*N is not a power of 2):
  - Writes are ignored.
  - Reads return 0.
- Reset asserted mid-computation: immediate abort to IDLE with all arrays cleared. No done pulse is issued.

Optional Feature:
Macro MATMULT_SIGNED_EN.
- Defined: elements are two's complement. Operands are sign-extended, products and acc are signed, and C is written as a signed CW-bit value.
- Undefined: all arithmetic is unsigned, as above.
- Timing and handshakes are identical in both builds.

Decomposition:
- Package matmult_pkg holds:
  - state enum (IDLE, MAC, DONE);
  - functions computing IW and CW from N and DW;
  - row-major index helper idx(r,c,N).
- Sub-module matmult_mac:
  - inputs: a, b, clear, last;
  - output: acc;
  - contains the multiplier and accumulator, plus the MATMULT_SIGNED_EN extension logic.
- FSM, counters and storage stay in matmult_core.

Test Plan:
- Basic product, N=2, DW=8: write A=[1,2;3,4], B=[5,6;7,8], then start -> busy high for 8 cycles, done in cycle t+9, reads return C=[19,22;43,50].
- Maximum unsigned operands: all A and B elements = 255 -> every C element = 130050 (0x1FC02), with no truncation in CW=17.
- Start during computation: pulse start again at cycle t+3 -> no restart, done still at t+9; a following idle start recomputes the same C.
- Write while busy: write A[0]=9 at cycle t+2 -> ignored, C[0]=19. A write plus start at the same edge with A[0]=9 -> C[0]=9*5+2*7=59.
- Reset mid-run: deassert ARESETN at cycle t+4 -> busy=0 immediately, no done pulse, all reads return 0.
- Signed build (MATMULT_SIGNED_EN): A=[-1,2;3,-4] (0xFF,0x02,0x03,0xFC), B=[5,6;7,8] -> C=[9,10;-13,-14], read as 17-bit two's complement.

Source files
------------

// File: rtl/matmult_pkg.sv
// Shared types and sizing helpers for the matmult compute engine.
package matmult_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMac  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Index width for an N x N row-major element array.
   function automatic int unsigned calc_iw(input int unsigned n);
      return $clog2(n * n);
   endfunction

   // Result width: full product plus headroom for N accumulated terms.
   function automatic int unsigned calc_cw(input int unsigned n, input int unsigned dw);
      return 2 * dw + $clog2(n);
   endfunction

   function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                       input int unsigned n);
      return r * n + c;
   endfunction

endpackage

// File: rtl/matmult_mac.sv
// Multiply-accumulate datapath; acc presents the running sum including the current product.
// Build option MATMULT_SIGNED_EN selects two's-complement operands.
module matmult_mac
   import matmult_pkg::*;
#(
   parameter int unsigned DW = 8,
   parameter int unsigned CW = 17
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          clear,
   input  logic          last,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [CW-1:0] acc
);

   logic [CW-1:0] a_ext;
   logic [CW-1:0] b_ext;
   logic [CW-1:0] prod;
   logic [CW-1:0] acc_d;
   logic [CW-1:0] acc_q;

   // Modulo-2^CW arithmetic on extended operands is exact for both signednesses.
   always_comb begin
`ifdef MATMULT_SIGNED_EN
      a_ext = {{(CW - DW){a[DW-1]}}, a};
      b_ext = {{(CW - DW){b[DW-1]}}, b};
`else
      a_ext = {{(CW - DW){1'b0}}, a};
      b_ext = {{(CW - DW){1'b0}}, b};
`endif
      prod = a_ext * b_ext;
      acc  = acc_q + prod;
   end

   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = last ? '0 : acc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/matmult_core.sv
// N x N matrix multiply engine: operand/result storage, loop counters and control FSM.
// MATMULT_SIGNED_EN (in matmult_mac) switches to two's-complement arithmetic.
module matmult_core
   import matmult_pkg::*;
#(
   parameter  int unsigned N  = 2,
   parameter  int unsigned DW = 8,
   localparam int unsigned IW = calc_iw(N),
   localparam int unsigned CW = calc_cw(N, DW)
) (
   input  logic          ACLK,
   input  logic          ARESETN,
   input  logic          wr_en,
   input  logic          wr_sel,
   input  logic [IW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic [IW-1:0] rd_addr,
   output logic [CW-1:0] rd_data
);

   localparam int unsigned NN   = N * N;
   localparam int unsigned CntW = $clog2(N);
   localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);
   localparam logic [IW:0]     NnLim   = (IW + 1)'(NN);

   state_e state_q, state_d;

   logic [CntW-1:0] i_q, i_d;
   logic [CntW-1:0] j_q, j_d;
   logic [CntW-1:0] k_q, k_d;

   logic [DW-1:0] a_q [NN];
   logic [DW-1:0] a_d [NN];
   logic [DW-1:0] b_q [NN];
   logic [DW-1:0] b_d [NN];
   logic [CW-1:0] c_q [NN];
   logic [CW-1:0] c_d [NN];

   logic [CW-1:0] rd_data_q, rd_data_d;

   logic          last_i, last_j, last_k, last_elem;
   logic          in_mac, accept_start, wr_ok;
   logic [IW-1:0] a_idx, b_idx, c_idx;
   logic [CW-1:0] mac_acc;

   assign in_mac       = (state_q == StMac);
   assign accept_start = (state_q == StIdle) && start;
   assign last_i       = (i_q == LastIdx);
   assign last_j       = (j_q == LastIdx);
   assign last_k       = (k_q == LastIdx);
   assign last_elem    = last_i && last_j && last_k;

   // Out-of-range indices only exist when N*N is not a power of two.
   assign wr_ok = wr_en && !in_mac && ({1'b0, wr_addr} < NnLim);

   assign a_idx = IW'(idx(32'(i_q), 32'(k_q), N));
   assign b_idx = IW'(idx(32'(k_q), 32'(j_q), N));
   assign c_idx = IW'(idx(32'(i_q), 32'(j_q), N));

   matmult_mac #(
      .DW (DW),
      .CW (CW)
   ) u_mac (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .en    (in_mac),
      .clear (accept_start),
      .last  (last_k),
      .a     (a_q[a_idx]),
      .b     (b_q[b_idx]),
      .acc   (mac_acc)
   );

   // FSM: state register
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StMac;
         StMac:   if (last_elem) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         StMac:   busy = 1'b1;
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   // Loop counters walk k fastest, then j, then i.
   always_comb begin
      i_d = i_q;
      j_d = j_q;
      k_d = k_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               i_d = '0;
               j_d = '0;
               k_d = '0;
            end
         end
         StMac: begin
            if (last_k) begin
               k_d = '0;
               if (last_j) begin
                  j_d = '0;
                  i_d = last_i ? '0 : i_q + 1'b1;
               end else begin
                  j_d = j_q + 1'b1;
               end
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      if (wr_ok) begin
         if (wr_sel) begin
            b_d[wr_addr] = wr_data;
         end else begin
            a_d[wr_addr] = wr_data;
         end
      end
      if (in_mac && last_k) begin
         c_d[c_idx] = mac_acc;
      end
   end

   always_comb begin
      rd_data_d = '0;
      if ({1'b0, rd_addr} < NnLim) begin
         rd_data_d = c_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         i_q       <= '0;
         j_q       <= '0;
         k_q       <= '0;
         rd_data_q <= '0;
         for (int n = 0; n < NN; n++) begin
            a_q[n] <= '0;
            b_q[n] <= '0;
            c_q[n] <= '0;
         end
      end else begin
         i_q       <= i_d;
         j_q       <= j_d;
         k_q       <= k_d;
         rd_data_q <= rd_data_d;
         a_q       <= a_d;
         b_q       <= b_d;
         c_q       <= c_d;
      end
   end

endmodule

// File: tb/tb_matmult_core.sv
// Directed self-checking bench for matmult_core with N=2, DW=8.
module tb_matmult_core;

   localparam int unsigned N  = 2;
   localparam int unsigned DW = 8;
   localparam int unsigned IW = 2;
   localparam int unsigned CW = 17;

   logic          ACLK    = 1'b0;
   logic          ARESETN = 1'b0;
   logic          wr_en   = 1'b0;
   logic          wr_sel  = 1'b0;
   logic [IW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          start   = 1'b0;
   logic [IW-1:0] rd_addr = '0;
   logic          busy;
   logic          done;
   logic [CW-1:0] rd_data;

   int nchk = 0;
   int nbad = 0;

   always #5 ACLK = ~ACLK;

   matmult_core #(
      .N  (N),
      .DW (DW)
   ) dut (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      nchk++;
      assert (obs === exp)
      else begin
         nbad++;
         $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // All tasks begin and end just after a falling edge.
   task automatic wr(input logic sel, input int addr, input int data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = IW'(addr);
      wr_data = DW'(data);
      @(negedge ACLK);
      wr_en   = 1'b0;
   endtask

   task automatic load(input int a0, a1, a2, a3, b0, b1, b2, b3);
      wr(1'b0, 0, a0); wr(1'b0, 1, a1); wr(1'b0, 2, a2); wr(1'b0, 3, a3);
      wr(1'b1, 0, b0); wr(1'b1, 1, b1); wr(1'b1, 2, b2); wr(1'b1, 3, b3);
   endtask

   task automatic chk_c(input string tag, input int e0, e1, e2, e3);
      int exp_v[4];
      exp_v = '{e0, e1, e2, e3};
      for (int n = 0; n < 4; n++) begin
         rd_addr = IW'(n);
         @(negedge ACLK);
         chk($sformatf("%s_c%0d", tag, n), int'(rd_data), exp_v[n]);
      end
   endtask

   // Pulse start (optionally with a simultaneous A[0] write), then watch 14 cycles.
   // restart_at / wr_at / rst_at are sample indices after the start edge (-1 = never).
   task automatic run(input int restart_at, input int wr_at, input int rst_at,
                      input bit wr_with_start, output int busy_cnt, output int done_at,
                      output int done_cnt);
      start = 1'b1;
      if (wr_with_start) begin
         wr_en   = 1'b1;
         wr_sel  = 1'b0;
         wr_addr = '0;
         wr_data = 8'd9;
      end
      @(negedge ACLK);
      start    = 1'b0;
      wr_en    = 1'b0;
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = -1;
      for (int s = 0; s < 14; s++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = s;
         end
         start   = (s == restart_at);
         wr_en   = (s == wr_at);
         wr_sel  = 1'b0;
         wr_addr = '0;
         wr_data = 8'd9;
         if (s == rst_at) begin
            ARESETN = 1'b0;
            #1;
            chk("rst_busy_now", int'(busy), 0);
            chk("rst_done_now", int'(done), 0);
         end
         @(negedge ACLK);
      end
      start   = 1'b0;
      wr_en   = 1'b0;
      ARESETN = 1'b1;
      @(negedge ACLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bc, da, dc;

      // Reset state
      @(negedge ACLK);
      @(negedge ACLK);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_rd", int'(rd_data), 0);
      ARESETN = 1'b1;
      @(negedge ACLK);
      chk_c("reset_c", 0, 0, 0, 0);

      // Basic product
      load(1, 2, 3, 4, 5, 6, 7, 8);
      run(-1, -1, -1, 1'b0, bc, da, dc);
      chk("basic_busy_cycles", bc, 8);
      chk("basic_done_at", da, 8);
      chk("basic_done_count", dc, 1);
      chk_c("basic", 19, 22, 43, 50);

      // Start during computation is ignored; a later idle start recomputes
      run(2, -1, -1, 1'b0, bc, da, dc);
      chk("restart_busy_cycles", bc, 8);
      chk("restart_done_at", da, 8);
      chk("restart_done_count", dc, 1);
      run(-1, -1, -1, 1'b0, bc, da, dc);
      chk("rerun_done_at", da, 8);
      chk_c("rerun", 19, 22, 43, 50);

      // Write while busy is dropped; write together with start is used
      run(-1, 1, -1, 1'b0, bc, da, dc);
      chk("busywr_done_at", da, 8);
      chk_c("busywr", 19, 22, 43, 50);
      run(-1, -1, -1, 1'b1, bc, da, dc);
      chk("wrstart_done_at", da, 8);
      chk_c("wrstart", 59, 70, 43, 50);

`ifndef MATMULT_SIGNED_EN
      // Full-scale unsigned operands: 2*255*255 = 130050
      load(255, 255, 255, 255, 255, 255, 255, 255);
      run(-1, -1, -1, 1'b0, bc, da, dc);
      chk_c("maxval", 130050, 130050, 130050, 130050);
`else
      // Two's-complement operands; negative results read as 17-bit patterns
      load(8'hFF, 2, 3, 8'hFC, 5, 6, 7, 8);
      run(-1, -1, -1, 1'b0, bc, da, dc);
      chk_c("signed", 9, 10, 17'h1FFF3, 17'h1FFF2);
`endif

      // Reset mid-run: abort with no done pulse, all storage cleared
      load(1, 2, 3, 4, 5, 6, 7, 8);
      run(-1, -1, 3, 1'b0, bc, da, dc);
      chk("midrst_busy_cycles", bc, 4);
      chk("midrst_done_count", dc, 0);
      chk_c("midrst", 0, 0, 0, 0);
      run(-1, -1, -1, 1'b0, bc, da, dc);
      chk("postrst_done_at", da, 8);
      chk_c("postrst", 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end

endmodule
